// File: rtl/dog_pkg.sv
// rtl/dog_pkg.sv - shared widths, frame defaults and packed-field helpers for the DoG stage.
package dog_pkg;

  localparam int COLS_DEF = 640;
  localparam int ROWS_DEF = 480;
  localparam int COL_W    = 10;
  localparam int ROW_W    = 9;

  // One guard bit above the pixel width holds any difference of two unsigned pixels exactly.
  function automatic int out_w(input int pix_w);
    return pix_w + 1;
  endfunction

  function automatic int diff_off(input int k, input int ow);
    return k * ow;
  endfunction

endpackage

// File: rtl/dog_diff_stream_if.sv
// rtl/dog_diff_stream_if.sv - input/output beat bundle of the DoG stage; DOG_THRESH_EN adds thresh/out_sig.
interface dog_diff_stream_if
  import dog_pkg::*;
#(
  parameter int PIX_W    = 9,
  parameter int N_SCALES = 4
);
  localparam int OUT_W = out_w(PIX_W);

  logic                            in_valid;
  logic                            in_ready;
  logic                            in_sof;
  logic [N_SCALES*PIX_W-1:0]       in_pix;
  logic                            out_valid;
  logic                            out_ready;
  logic [(N_SCALES-1)*OUT_W-1:0]   out_diff;
  logic [COL_W-1:0]                out_col;
  logic [ROW_W-1:0]                out_row;
  logic                            out_sof;
  logic                            out_eol;
  logic                            out_eof;
  logic                            sync_err;
`ifdef DOG_THRESH_EN
  logic [PIX_W-1:0]                thresh;
  logic [N_SCALES-2:0]             out_sig;
`endif

  modport master (
    output in_valid, in_sof, in_pix, out_ready,
`ifdef DOG_THRESH_EN
    output thresh,
    input  out_sig,
`endif
    input  in_ready, out_valid, out_diff, out_col, out_row, out_sof, out_eol, out_eof, sync_err
  );

  modport slave (
    input  in_valid, in_sof, in_pix, out_ready,
`ifdef DOG_THRESH_EN
    input  thresh,
    output out_sig,
`endif
    output in_ready, out_valid, out_diff, out_col, out_row, out_sof, out_eol, out_eof, sync_err
  );

endinterface

// File: rtl/dog_pix_counter.sv
// rtl/dog_pix_counter.sv - column/row tracker with sof resync, sticky sync_err and beat position tags.
module dog_pix_counter
  import dog_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept_i,
  input  logic             sof_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             sof_o,
  output logic             eol_o,
  output logic             eof_o,
  output logic             sync_err_o
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             sync_err_q, sync_err_d;
  logic             at_origin, last_col, last_row;

  assign at_origin = (col_q == '0) && (row_q == '0);

  // An input sof forces this beat to be pixel (0,0) regardless of where the counters were.
  assign col_o    = sof_i ? '0 : col_q;
  assign row_o    = sof_i ? '0 : row_q;
  assign last_col = (col_o == COL_W'(COLS - 1));
  assign last_row = (row_o == ROW_W'(ROWS - 1));

  assign sof_o      = (col_o == '0) && (row_o == '0);
  assign eol_o      = last_col;
  assign eof_o      = last_col && last_row;
  assign sync_err_o = sync_err_q;

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    sync_err_d = sync_err_q | (accept_i & sof_i & ~at_origin);
    if (accept_i) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_o + ROW_W'(1);
      end else begin
        col_d = col_o + COL_W'(1);
        row_d = row_o;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      sync_err_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      sync_err_q <= sync_err_d;
    end
  end

endmodule

// File: rtl/dog_diff_stream.sv
// rtl/dog_diff_stream.sv - streaming Difference-of-Gaussian stage, scale[k+1]-scale[k] per pixel.
// Optional DOG_THRESH_EN: zero small diffs and flag significant ones on out_sig.
module dog_diff_stream
  import dog_pkg::*;
#(
  parameter int PIX_W    = 9,
  parameter int N_SCALES = 4,
  parameter int COLS     = COLS_DEF,
  parameter int ROWS     = ROWS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  dog_diff_stream_if.slave   bus
);

  localparam int OUT_W = out_w(PIX_W);
  localparam int DW    = (N_SCALES - 1) * OUT_W;

  logic             in_ready, accept;
  logic             out_valid_q;
  logic [DW-1:0]    out_diff_q, diff_d;
  logic [COL_W-1:0] out_col_q, pos_col;
  logic [ROW_W-1:0] out_row_q, pos_row;
  logic             out_sof_q, out_eol_q, out_eof_q;
  logic             tag_sof, tag_eol, tag_eof, sync_err;

  assign in_ready = ~out_valid_q | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;

  dog_pix_counter #(.COLS(COLS), .ROWS(ROWS)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .accept_i   (accept),
    .sof_i      (bus.in_sof),
    .col_o      (pos_col),
    .row_o      (pos_row),
    .sof_o      (tag_sof),
    .eol_o      (tag_eol),
    .eof_o      (tag_eof),
    .sync_err_o (sync_err)
  );

`ifdef DOG_THRESH_EN
  logic [N_SCALES-2:0] sig_d, out_sig_q;
`endif

  for (genvar k = 0; k < N_SCALES - 1; k++) begin : g_diff
    logic [OUT_W-1:0] hi, lo, raw;
    assign hi  = {1'b0, bus.in_pix[(k+1)*PIX_W +: PIX_W]};
    assign lo  = {1'b0, bus.in_pix[k*PIX_W +: PIX_W]};
    assign raw = hi - lo;
`ifdef DOG_THRESH_EN
    logic [OUT_W-1:0] mag;
    logic             keep;
    assign mag  = raw[OUT_W-1] ? (~raw + OUT_W'(1)) : raw;
    assign keep = (mag >= {1'b0, bus.thresh});
    assign diff_d[diff_off(k, OUT_W) +: OUT_W] = keep ? raw : '0;
    assign sig_d[k] = keep & (bus.thresh != '0);
`else
    assign diff_d[diff_off(k, OUT_W) +: OUT_W] = raw;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_diff_q  <= '0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
`ifdef DOG_THRESH_EN
      out_sig_q   <= '0;
`endif
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_diff_q  <= diff_d;
      out_col_q   <= pos_col;
      out_row_q   <= pos_row;
      out_sof_q   <= tag_sof;
      out_eol_q   <= tag_eol;
      out_eof_q   <= tag_eof;
`ifdef DOG_THRESH_EN
      out_sig_q   <= sig_d;
`endif
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_diff  = out_diff_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eol   = out_eol_q;
  assign bus.out_eof   = out_eof_q;
  assign bus.sync_err  = sync_err;
`ifdef DOG_THRESH_EN
  assign bus.out_sig   = out_sig_q;
`endif

endmodule

// File: doc/dog_diff_stream.md
Name: dog_diff_stream

Overview:
- Streaming Difference-of-Gaussian stage for the SIFT pipeline.
- Accepts one pixel per beat from N_SCALES blurred images of the same octave, for example the 3x3, 5x5 and 7x7 blur outputs.
- Emits N_SCALES-1 signed differences per pixel: scale[k+1] minus scale[k].
- Tags each output beat with column/row position and frame markers, and checks frame alignment against an input start-of-frame marker.
- Sits between the Gaussian blur bank and the keypoint (extremum) detector.

Parameters:
- PIX_W, 9: unsigned width of each blurred pixel.
- N_SCALES, 4: number of blurred scales in; must be at least 2.
- COLS, 640: pixels per row.
- ROWS, 480: rows per frame.
- OUT_W, PIX_W+1: signed width of each difference. Fixed relation; not overridable below PIX_W+1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid and in_ready are both 1.
- in_sof  in  1  marks the beat as pixel (0,0) of a frame.
- in_pix  in  N_SCALES*PIX_W  packed scales, scale 0 in the LSBs.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_diff  out  (N_SCALES-1)*OUT_W  packed signed diffs, diff 0 (scale1-scale0) in the LSBs.
- out_col  out  10  column of the output pixel.
- out_row  out  9  row of the output pixel.
- out_sof  out  1  output pixel is (0,0).
- out_eol  out  1  output pixel is col COLS-1.
- out_eof  out  1  output pixel is (COLS-1, ROWS-1).
- sync_err  out  1  sticky frame-misalignment flag.

Behaviour:
- Reset (async assert, sync deassert in use): every output register is 0, col/row counters are 0, and in_ready is 1 after reset.
- Arithmetic: diff[k] = sign-extended {1'b0,scale[k+1]} minus {1'b0,scale[k]}. The result is exact in OUT_W bits; no saturation.
  - Example: 5 - 6 = -1, i.e. 0x3FF at OUT_W=10.
  - Example: 6 - 5 = +1.
- Pipeline: one output register stage.
  - in_ready = ~out_valid | out_ready (combinational).
  - On an accepted beat, out_* load on the next edge; latency is 1 cycle.
  - If out_valid and ~out_ready, out_* hold stable and in_ready = 0. No beat is dropped or duplicated.
  - If out_ready and no new accept, out_valid clears on the next edge.
- Position counters advance only on accept:
  - col increments; at COLS-1 it wraps to 0 and row increments.
  - At (COLS-1, ROWS-1) both wrap to 0.
- The position and tags are captured with the beat: sof when (col,row) = (0,0), eol when col = COLS-1, eof at the last pixel.
- Frame sync on an accepted beat with in_sof = 1:
  - Counters at (0,0): normal.
  - Counters not at (0,0): set sync_err. That beat is treated as (0,0): out_sof = 1, and the counters continue from (1,0).
- sync_err clears only on rst.
- in_sof on a non-accepted cycle is ignored.
- Reset mid-frame: any in-flight output beat is discarded, and counters return to (0,0).

Optional Feature:
- Macro: DOG_THRESH_EN.
- When defined:
  - Adds input port thresh [PIX_W-1:0] and output port out_sig [N_SCALES-2:0].
  - Any diff with |diff| < thresh is forced to 0 in out_diff.
  - out_sig[k] = 1 iff |diff[k]| >= thresh and thresh != 0.
  - thresh is sampled with the beat on accept.
- When not defined: no extra ports; diffs pass unmodified.

Decomposition:
- Shared package dog_pkg holds:
  - localparams for COLS/ROWS defaults;
  - counter widths COL_W=10 and ROW_W=9;
  - a function for the packed-field offset k*OUT_W;
  - the OUT_W derivation.
- One sub-module is natural: dog_pix_counter, holding the col/row counters with wrap, sof resync, the sync_err sticky flag and the tag generation.
- The difference array is a generate loop in the top.

Test Plan:
- Reset, then one beat with scales {6,5,...}:
  - scale0=6, scale1=5 gives diff0 = -1 (0x3FF).
  - Swapped (scale0=5, scale1=6) gives +1.
  - out_valid is high exactly 1 cycle after accept.
- Extremes: scale0=511, scale1=0 gives -511 (0x201); the reverse gives +511 (0x1FF). No wrap errors.
- Full frame at COLS=4, ROWS=2, with in_valid=1 and out_ready=1 throughout:
  - 8 outputs appear.
  - out_sof only on beat 0; out_eol on beats 3 and 7; out_eof on beat 7.
  - The counters then return to (0,0).
- Backpressure: hold out_ready=0 for 5 cycles mid-stream. Then:
  - in_ready = 0 throughout;
  - out_diff is stable;
  - after release, the sequence is intact with no loss or duplicate.
- Misaligned sof: assert in_sof at beat 3 of a frame.
  - sync_err rises and stays high.
  - That output has out_sof=1 and col=0; the next output has col=1.
- With DOG_THRESH_EN and thresh=4: diffs {3,-4,10} give out_diff {0,-4,10} and out_sig = 3'b110.
